// File: rtl/branch_seq.sv
// Conditional-branch sequencer: one-hot FSM whose state flops are the bus strobes (taken: 5 cycles, not taken: 4).
// start is sampled only in IDLE; requests while busy are dropped, bad opcodes pulse bad_op and stay in IDLE.
module branch_seq #(
  parameter int         BITS      = 32,
  parameter logic [4:0] BR_OPCODE = 5'b10010,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [BITS-1:0]  ir,
  input  logic             con,
  input  logic             clr_stats,
  output logic [1:0]       c2_sel,
  output logic             Gra,
  output logic             Rout,
  output logic             CON_in,
  output logic             PCout,
  output logic             Yin,
  output logic             Cout,
  output logic             ADD,
  output logic             Zin,
  output logic             Zlowout,
  output logic             PCin,
  output logic             busy,
  output logic             done,
  output logic             taken,
  output logic             bad_op,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] ntaken_cnt
);

  localparam int I_IDLE = 0;
  localparam int I_RA   = 1;
  localparam int I_PCY  = 2;
  localparam int I_ADD  = 3;
  localparam int I_PCLD = 4;
  localparam int I_DONE = 5;

  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_RA   = 6'b000010,
    S_PCY  = 6'b000100,
    S_ADD  = 6'b001000,
    S_PCLD = 6'b010000,
    S_DONE = 6'b100000
  } state_t;

  state_t state, state_d;
  logic   opcode_ok;
  logic   accept;
  logic   unused_ir;

  assign opcode_ok = (ir[BITS-1 -: 5] == BR_OPCODE);
  assign accept    = state[I_IDLE] && start && opcode_ok;
  assign unused_ir = ^ir[BITS-6:2];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= S_IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:  if (accept) state_d = S_RA;
      S_RA:    state_d = S_PCY;
      S_PCY:   state_d = S_ADD;
      S_ADD:   state_d = con ? S_PCLD : S_DONE;
      S_PCLD:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes come straight off the one-hot flops, so CON_in cannot glitch.
  assign Gra     = state[I_RA];
  assign Rout    = state[I_RA];
  assign CON_in  = state[I_RA];
  assign PCout   = state[I_PCY];
  assign Yin     = state[I_PCY];
  assign Cout    = state[I_ADD];
  assign ADD     = state[I_ADD];
  assign Zin     = state[I_ADD];
  assign Zlowout = state[I_PCLD];
  assign PCin    = state[I_PCLD];
  assign busy    = ~state[I_IDLE];
  assign done    = state[I_DONE];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      c2_sel     <= 2'b00;
      bad_op     <= 1'b0;
      taken      <= 1'b0;
      taken_cnt  <= '0;
      ntaken_cnt <= '0;
    end else begin
      bad_op <= state[I_IDLE] && start && !opcode_ok;
      if (accept) c2_sel <= ir[1:0];
      // taken reflects the condition sampled in ADD and is visible from DONE onward.
      if (state[I_ADD] && !con) taken <= 1'b0;
      else if (state[I_PCLD])   taken <= 1'b1;
      if (clr_stats) begin
        taken_cnt  <= '0;
        ntaken_cnt <= '0;
      end else if (state[I_DONE]) begin
        if (taken && (taken_cnt != '1))    taken_cnt  <= taken_cnt + CNT_W'(1);
        if (!taken && (ntaken_cnt != '1)) ntaken_cnt <= ntaken_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_seq.sv
// Randomized bench for branch_seq: per-branch expected strobe timeline and saturating counter model.
module tb_branch_seq;

  localparam int         CW   = 4;
  localparam int         CMAX = (1 << CW) - 1;
  localparam logic [4:0] BR   = 5'b10010;

  logic          clk;
  logic          clr;
  logic          start;
  logic [31:0]   ir;
  logic          con;
  logic          clr_stats;
  logic [1:0]    c2_sel;
  logic          Gra, Rout, CON_in, PCout, Yin, Cout, ADD, Zin, Zlowout, PCin;
  logic          busy, done, taken, bad_op;
  logic [CW-1:0] taken_cnt, ntaken_cnt;

  logic [11:0]   strobes;
  logic [23:0]   all_out;

  int n_tests = 0;
  int n_fail  = 0;
  int m_tk    = 0;
  int m_nt    = 0;

  branch_seq #(.BITS(32), .BR_OPCODE(BR), .CNT_W(CW)) dut (
    .clk(clk), .clr(clr), .start(start), .ir(ir), .con(con), .clr_stats(clr_stats),
    .c2_sel(c2_sel), .Gra(Gra), .Rout(Rout), .CON_in(CON_in), .PCout(PCout), .Yin(Yin),
    .Cout(Cout), .ADD(ADD), .Zin(Zin), .Zlowout(Zlowout), .PCin(PCin), .busy(busy),
    .done(done), .taken(taken), .bad_op(bad_op), .taken_cnt(taken_cnt), .ntaken_cnt(ntaken_cnt)
  );

  assign strobes = {Gra, Rout, CON_in, PCout, Yin, Cout, ADD, Zin, Zlowout, PCin, busy, done};
  assign all_out = {c2_sel, strobes, taken, bad_op, taken_cnt, ntaken_cnt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Expected {Gra,Rout,CON_in,PCout,Yin,Cout,ADD,Zin,Zlowout,PCin,busy,done} in cycle k after the start edge.
  function automatic logic [11:0] exp_strobes(input int k, input bit cond);
    int d;
    logic [11:0] v;
    d = cond ? 5 : 4;
    v = '0;
    if (k == 1) v[11:9] = 3'b111;
    if (k == 2) v[8:7]  = 2'b11;
    if (k == 3) v[6:4]  = 3'b111;
    if (cond && k == 4) v[3:2] = 2'b11;
    v[1] = (k >= 1) && (k <= d);
    v[0] = (k == d);
    return v;
  endfunction

  // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
  task automatic run_br(input bit cond, input logic [1:0] c2, input int cs);
    int d;
    logic [31:0] w;
    d = cond ? 5 : 4;
    if (cs >= 1 && cs < d) begin m_tk = 0; m_nt = 0; end
    if (cs == d) begin m_tk = 0; m_nt = 0; end
    else if (cond) m_tk = sat_inc(m_tk);
    else           m_nt = sat_inc(m_nt);
    w = $urandom;
    w[31:27] = BR;
    w[1:0] = c2;
    start = 1'b1; ir = w; con = 1'($urandom_range(0, 1)); clr_stats = 1'b0;
    for (int k = 1; k <= d + 1; k++) begin
      @(negedge clk);
      check("strobes", strobes, exp_strobes(k, cond));
      check("bad_op_busy", bad_op, 1'b0);
      if (k <= d) check("c2_sel", c2_sel, c2);
      if (k >= d) check("taken", taken, cond);
      if (k == d + 1) begin
        check("taken_cnt", taken_cnt, m_tk);
        check("ntaken_cnt", ntaken_cnt, m_nt);
      end
      start = (k <= d) ? 1'($urandom_range(0, 1)) : 1'b0;
      ir = $urandom;
      con = (k == 1) ? 1'($urandom_range(0, 1)) : cond;
      clr_stats = (k == cs);
    end
  endtask

  task automatic bad_op_test();
    logic [31:0] w;
    logic [4:0]  op;
    op = 5'($urandom_range(0, 31));
    if (op == BR) op = 5'b00011;
    w = $urandom;
    w[31:27] = op;
    start = 1'b1; ir = w;
    @(negedge clk);
    check("bad_op_pulse", bad_op, 1'b1);
    check("bad_op_busy1", busy, 1'b0);
    start = 1'b0;
    @(negedge clk);
    check("bad_op_end", bad_op, 1'b0);
    check("bad_op_busy2", busy, 1'b0);
    check("bad_op_tk", taken_cnt, m_tk);
    check("bad_op_nt", ntaken_cnt, m_nt);
  endtask

  task automatic hold_test();
    logic [31:0] w;
    logic [1:0]  c2a, c2b;
    int dones, pcins;
    dones = 0; pcins = 0; c2b = 2'b00;
    w = $urandom; w[31:27] = BR; c2a = w[1:0];
    start = 1'b1; ir = w; con = 1'b1; clr_stats = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      dones += int'(done);
      pcins += int'(PCin);
      check("hold_busy", busy, !(k == 6 || k == 12));
      if (k >= 1 && k <= 5)  check("hold_c2_a", c2_sel, c2a);
      if (k >= 7 && k <= 11) check("hold_c2_b", c2_sel, c2b);
      w = $urandom; w[31:27] = BR;
      if (k == 6) c2b = w[1:0];
      ir = w;
      start = (k <= 11);
    end
    check("hold_dones", dones, 2);
    check("hold_pcins", pcins, 2);
    m_tk = sat_inc(sat_inc(m_tk));
  endtask

  task automatic reset_test();
    logic [31:0] w;
    w = $urandom; w[31:27] = BR;
    start = 1'b1; ir = w; con = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rst_pre_pcy", strobes, exp_strobes(2, 1'b1));
    clr = 1'b0;
    #1;
    check("rst_async", all_out, 24'h0);
    m_tk = 0; m_nt = 0;
    @(negedge clk);
    check("rst_held", all_out, 24'h0);
    clr = 1'b1;
    @(negedge clk);
    check("rst_released", all_out, 24'h0);
  endtask

  initial begin
    int cs, d;
    bit cond;
    clr = 1'b0; start = 1'b0; ir = '0; con = 1'b0; clr_stats = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", all_out, 24'h0);
    clr = 1'b1;
    @(negedge clk);
    check("idle_after_reset", all_out, 24'h0);

    run_br(1'b1, 2'b00, 0);
    run_br(1'b0, 2'b01, 0);
    repeat (3) bad_op_test();
    hold_test();
    reset_test();
    run_br(1'b1, 2'($urandom_range(0, 3)), 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) bad_op_test();
      else begin
        cond = ($urandom_range(0, 99) < 70);
        d = cond ? 5 : 4;
        cs = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, d)) : 0;
        run_br(cond, 2'($urandom_range(0, 3)), cs);
      end
    end

    for (int i = 0; i < CMAX + 2; i++) run_br(1'b1, 2'($urandom_range(0, 3)), 0);
    for (int i = 0; i < CMAX + 2; i++) run_br(1'b0, 2'($urandom_range(0, 3)), 0);
    check("sat_tk", taken_cnt, CMAX);
    check("sat_nt", ntaken_cnt, CMAX);
    run_br(1'b1, 2'b10, 5);
    run_br(1'b0, 2'b11, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
